// File: rtl/intc_lite_pkg.sv
// intc_lite_pkg: shared register indices, MER position, IVR "none" value and byte-enable helper.
package intc_lite_pkg;
  localparam int ISR_IDX = 0;
  localparam int IER_IDX = 1;
  localparam int MODE_IDX = 2;
  localparam int IVR_IDX = 3;
  localparam int MER_BIT = 31;
  localparam logic [31:0] IVR_NONE = 32'hFFFF_FFFF;
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction
endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: index of the lowest-numbered set request bit.
module intc_prio_enc #(
  parameter int C_NUM_INTR = 8
) (
  input  logic [C_NUM_INTR-1:0] req,
  output logic                  valid,
  output logic [4:0]            idx
);
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = C_NUM_INTR - 1; i >= 0; i--) if (req[i]) idx = 5'(i);
  end
endmodule

// File: rtl/intc_lite.sv
// intc_lite: bus-mapped interrupt controller with edge/level sources, W1C status and IVR.
module intc_lite
  import intc_lite_pkg::*;
#(
  parameter int C_NUM_REG = 4,
  parameter int C_SLV_DWIDTH = 32,
  parameter int C_NUM_INTR = 8
) (
  input  logic                      Bus2IP_Clk,
  input  logic                      Bus2IP_Resetn,
  input  logic [C_NUM_INTR-1:0]     Int_In,
  output logic                      Irq,
  input  logic [C_SLV_DWIDTH-1:0]   Bus2IP_Data,
  input  logic [C_SLV_DWIDTH/8-1:0] Bus2IP_BE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_RdCE,
  input  logic [C_NUM_REG-1:0]      Bus2IP_WrCE,
  output logic [C_SLV_DWIDTH-1:0]   IP2Bus_Data,
  output logic                      IP2Bus_RdAck,
  output logic                      IP2Bus_WrAck,
  output logic                      IP2Bus_Error
);
  localparam logic [C_NUM_REG-1:0] CE_ISR = C_NUM_REG'(1) << (C_NUM_REG - 1 - ISR_IDX);
  localparam logic [C_NUM_REG-1:0] CE_IER = C_NUM_REG'(1) << (C_NUM_REG - 1 - IER_IDX);
  localparam logic [C_NUM_REG-1:0] CE_MODE = C_NUM_REG'(1) << (C_NUM_REG - 1 - MODE_IDX);
  localparam logic [C_NUM_REG-1:0] CE_IVR = C_NUM_REG'(1) << (C_NUM_REG - 1 - IVR_IDX);
  logic [C_NUM_INTR-1:0] s1, s2, isr, ier, mode, set_v, clr_v, pend;
  logic mer, valid;
  logic [4:0] idx;
  logic [C_SLV_DWIDTH-1:0] wmask, wdata, ivr;
  logic unused_wdata;
  assign wmask = be_mask(Bus2IP_BE);
  assign wdata = Bus2IP_Data & wmask;
  assign unused_wdata = ^wdata[MER_BIT-1:C_NUM_INTR];
  // Edge mode needs a fresh rise (s1 & ~s2); level mode only needs s1 high.
  assign set_v = s1 & ~(mode & s2);
  assign clr_v = (Bus2IP_WrCE == CE_ISR) ? wdata[C_NUM_INTR-1:0] : '0;
  assign pend = isr & ier;
  intc_prio_enc #(.C_NUM_INTR(C_NUM_INTR)) u_prio (
    .req  (pend),
    .valid(valid),
    .idx  (idx)
  );
  assign ivr = valid ? C_SLV_DWIDTH'(idx) : IVR_NONE;
  always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
    if (!Bus2IP_Resetn) begin
      s1 <= '0;
      s2 <= '0;
      isr <= '0;
      ier <= '0;
      mode <= '0;
      mer <= 1'b0;
      Irq <= 1'b0;
    end else begin
      s1 <= Int_In;
      s2 <= s1;
      isr <= (isr & ~clr_v) | set_v;
      if (Bus2IP_WrCE == CE_IER) ier <= (ier & ~wmask[C_NUM_INTR-1:0]) | wdata[C_NUM_INTR-1:0];
      if (Bus2IP_WrCE == CE_MODE) begin
        mode <= (mode & ~wmask[C_NUM_INTR-1:0]) | wdata[C_NUM_INTR-1:0];
        mer <= wmask[MER_BIT] ? wdata[MER_BIT] : mer;
      end
      Irq <= mer & |pend;
    end
  end
  assign IP2Bus_Data = (Bus2IP_RdCE == CE_ISR) ? C_SLV_DWIDTH'(isr) :
                       (Bus2IP_RdCE == CE_IER) ? C_SLV_DWIDTH'(ier) :
                       (Bus2IP_RdCE == CE_MODE) ? (C_SLV_DWIDTH'(mode) | (C_SLV_DWIDTH'(mer) << MER_BIT)) :
                       (Bus2IP_RdCE == CE_IVR) ? ivr : '0;
  assign IP2Bus_RdAck = |Bus2IP_RdCE;
  assign IP2Bus_WrAck = |Bus2IP_WrCE;
  assign IP2Bus_Error = 1'b0;
endmodule

// File: tb/tb_intc_lite.sv
// tb_intc_lite: random and directed stimulus checked every cycle against a behavioural model.
module tb_intc_lite;
  localparam int NI = 8;
  localparam logic [31:0] NM = 32'h0000_00FF;
  logic clk = 1'b0, rstn = 1'b0;
  logic [7:0] int_in = '0;
  logic irq, rdack, wrack, err;
  logic [31:0] data = '0, rdata;
  logic [3:0] be = '0, rdce = '0, wrce = '0;
  int checks = 0, failures = 0;
  logic [31:0] m_s1, m_s2, m_isr, m_ier, m_mode;
  logic m_mer, m_irq;

  always #5 clk = ~clk;

  intc_lite dut (
    .Bus2IP_Clk   (clk),
    .Bus2IP_Resetn(rstn),
    .Int_In       (int_in),
    .Irq          (irq),
    .Bus2IP_Data  (data),
    .Bus2IP_BE    (be),
    .Bus2IP_RdCE  (rdce),
    .Bus2IP_WrCE  (wrce),
    .IP2Bus_Data  (rdata),
    .IP2Bus_RdAck (rdack),
    .IP2Bus_WrAck (wrack),
    .IP2Bus_Error (err)
  );

  function automatic logic [31:0] bmask(input logic [3:0] b);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = b[k] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [31:0] m_set();
    logic [31:0] s = '0;
    for (int i = 0; i < NI; i++) s[i] = m_mode[i] ? (m_s1[i] & ~m_s2[i]) : m_s1[i];
    return s;
  endfunction

  function automatic logic [31:0] m_ivr();
    logic [31:0] p = m_isr & m_ier;
    for (int i = 0; i < NI; i++) if (p[i]) return 32'(i);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] m_rd(input logic [3:0] ce);
    case (ce)
      4'h8: return m_isr;
      4'h4: return m_ier;
      4'h2: return m_mode | {m_mer, 31'b0};
      4'h1: return m_ivr();
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_s1 <= '0; m_s2 <= '0; m_isr <= '0; m_ier <= '0; m_mode <= '0; m_mer <= 1'b0; m_irq <= 1'b0;
    end else begin
      m_irq <= m_mer && ((m_isr & m_ier) != 0);
      m_isr <= ((wrce == 4'h8) ? (m_isr & ~(data & bmask(be))) : m_isr) | m_set();
      if (wrce == 4'h4) m_ier <= ((m_ier & ~bmask(be)) | (data & bmask(be))) & NM;
      if (wrce == 4'h2) begin
        m_mode <= ((m_mode & ~bmask(be)) | (data & bmask(be))) & NM;
        if (be[3]) m_mer <= data[31];
      end
      m_s2 <= m_s1;
      m_s1 <= {24'b0, int_in};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    chk("rdata", rdata, m_rd(rdce));
    chk("rdack", {31'b0, rdack}, {31'b0, |rdce});
    chk("wrack", {31'b0, wrack}, {31'b0, |wrce});
    chk("error", {31'b0, err}, 32'h0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [3:0] ce, input logic [31:0] exp, input string nm);
    rdce = ce;
    #1;
    chk(nm, rdata, exp);
    rdce = '0;
  endtask

  task automatic wr(input logic [3:0] ce, input logic [31:0] d);
    wrce = ce; data = d; be = 4'hF;
    tick();
    wrce = '0; data = '0; be = '0;
  endtask

  task automatic irq_is(input logic e, input string nm);
    chk(nm, {31'b0, irq}, {31'b0, e});
  endtask

  logic [3:0] pats[8] = '{4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'h3, 4'hC, 4'hF};

  initial begin
    tick(); tick();
    rstn = 1'b1;
    tick();
    rd(4'h8, 32'h0, "rst_isr"); rd(4'h4, 32'h0, "rst_ier");
    rd(4'h2, 32'h0, "rst_mode"); rd(4'h1, 32'hFFFF_FFFF, "rst_ivr");
    irq_is(1'b0, "rst_irq");
    wr(4'h2, 32'h8000_0001); wr(4'h4, 32'h1);
    int_in = 8'h01; tick();
    int_in = 8'h00; irq_is(1'b0, "e_irq_e1");
    tick(); rd(4'h8, 32'h1, "e_isr"); irq_is(1'b0, "e_irq_e2");
    tick(); irq_is(1'b1, "e_irq_e3"); rd(4'h1, 32'h0, "e_ivr");
    wr(4'h8, 32'h1); rd(4'h8, 32'h0, "e_isr_clr"); irq_is(1'b1, "e_irq_hold");
    tick(); irq_is(1'b0, "e_irq_drop");
    wr(4'h2, 32'h8000_0000); wr(4'h4, 32'h4);
    int_in = 8'h04; tick(); tick(); tick();
    rd(4'h8, 32'h4, "l_isr"); irq_is(1'b1, "l_irq");
    wr(4'h8, 32'h4); rd(4'h8, 32'h4, "l_reset_isr"); irq_is(1'b1, "l_irq_stay");
    tick(); irq_is(1'b1, "l_irq_stay2");
    int_in = 8'h00; tick(); tick();
    wr(4'h8, 32'h4); rd(4'h8, 32'h0, "l_isr_clr");
    tick(); irq_is(1'b0, "l_irq_drop");
    int_in = 8'h28; tick();
    int_in = 8'h00; tick();
    rd(4'h8, 32'h28, "p_isr");
    wr(4'h4, 32'hFF); rd(4'h1, 32'h3, "p_ivr_ff");
    tick(); irq_is(1'b1, "p_irq");
    wr(4'h4, 32'hF0); rd(4'h1, 32'h5, "p_ivr_f0");
    wr(4'h4, 32'h00); rd(4'h1, 32'hFFFF_FFFF, "p_ivr_00");
    tick(); irq_is(1'b0, "p_irq_off");
    wr(4'h8, 32'hFF); wr(4'h2, 32'h8000_0002);
    int_in = 8'h02; tick();
    int_in = 8'h00; wr(4'h8, 32'h2);
    rd(4'h8, 32'h2, "sc_isr");
    wr(4'h2, 32'h8000_0000); wr(4'h4, 32'hFF);
    int_in = 8'hFF; tick(); tick(); tick();
    rd(4'h8, 32'hFF, "ar_isr_pre"); irq_is(1'b1, "ar_irq_pre");
    rstn = 1'b0; #1;
    irq_is(1'b0, "ar_irq"); rd(4'h8, 32'h0, "ar_isr"); rd(4'h4, 32'h0, "ar_ier");
    tick(); tick();
    rstn = 1'b1;
    tick(); rd(4'h8, 32'h0, "rd_isr_e1");
    tick(); rd(4'h8, 32'hFF, "rd_isr_e2"); rd(4'h2, 32'h0, "rd_mode"); irq_is(1'b0, "rd_irq");
    tick(); irq_is(1'b0, "rd_irq2");
    int_in = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      tick();
      rstn = ($urandom % 300) != 0;
      int_in = 8'($urandom);
      data = $urandom;
      be = 4'($urandom);
      wrce = ($urandom % 2) ? pats[$urandom % 8] : 4'h0;
      rdce = pats[$urandom % 8];
    end
    tick();
    rstn = 1'b1; wrce = '0; rdce = '0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
